// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - four-digit BCD stopwatch (SS.hh) with prescaler, run-state FSM and display hold
// Digit outputs are always 0-9 and feed one hex7seg decoder each.
module bcd_stopwatch #(
   parameter int TICK_DIV = 500000
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       START_STOP,
   input  logic       CLEAR,
   input  logic       HOLD,
   output logic [3:0] DIG3,
   output logic [3:0] DIG2,
   output logic [3:0] DIG1,
   output logic [3:0] DIG0,
   output logic       RUNNING,
   output logic       WRAP
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   typedef enum logic {STOPPED = 1'b0, RUN = 1'b1} state_t;

   state_t        state;
   logic          running;
   logic          ss1, ss2, ss3;
   logic          cl1, cl2, cl3;
   logic          hd1, hd2;
   logic          ss_pulse, cl_pulse, tick, all_nines;
   logic [PW-1:0] pre;
   logic [3:0]    d0, d1, d2, d3;
   logic          wrap;

   // START_STOP and CLEAR carry a third flop so only their rising edges act
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         ss1 <= 1'b0;
         ss2 <= 1'b0;
         ss3 <= 1'b0;
         cl1 <= 1'b0;
         cl2 <= 1'b0;
         cl3 <= 1'b0;
         hd1 <= 1'b0;
         hd2 <= 1'b0;
      end else begin
         ss1 <= START_STOP;
         ss2 <= ss1;
         ss3 <= ss2;
         cl1 <= CLEAR;
         cl2 <= cl1;
         cl3 <= cl2;
         hd1 <= HOLD;
         hd2 <= hd1;
      end
   end

   assign ss_pulse  = ss2 & ~ss3;
   assign cl_pulse  = cl2 & ~cl3;
   assign tick      = (state == RUN) && (pre == PRE_MAX);
   assign all_nines = (d0 == 4'd9) && (d1 == 4'd9) && (d2 == 4'd9) && (d3 == 4'd9);

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state   <= STOPPED;
         running <= 1'b0;
      end else if (ss_pulse) begin
         state   <= (state == RUN) ? STOPPED : RUN;
         running <= (state != RUN);
      end
   end

   // Holding pre while stopped keeps the partial hundredth across pause/resume
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         pre <= '0;
      end else if (cl_pulse) begin
         pre <= '0;
      end else if (state == RUN) begin
         pre <= tick ? '0 : pre + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         d0   <= 4'd0;
         d1   <= 4'd0;
         d2   <= 4'd0;
         d3   <= 4'd0;
         wrap <= 1'b0;
      end else if (cl_pulse) begin
         d0   <= 4'd0;
         d1   <= 4'd0;
         d2   <= 4'd0;
         d3   <= 4'd0;
         wrap <= 1'b0;
      end else if (tick) begin
         wrap <= all_nines;
         if (d0 != 4'd9) begin
            d0 <= d0 + 4'd1;
         end else begin
            d0 <= 4'd0;
            if (d1 != 4'd9) begin
               d1 <= d1 + 4'd1;
            end else begin
               d1 <= 4'd0;
               if (d2 != 4'd9) begin
                  d2 <= d2 + 4'd1;
               end else begin
                  d2 <= 4'd0;
                  d3 <= (d3 != 4'd9) ? d3 + 4'd1 : 4'd0;
               end
            end
         end
      end else begin
         wrap <= 1'b0;
      end
   end

   // Display register: tracks the live count one cycle behind unless held
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         DIG0 <= 4'd0;
         DIG1 <= 4'd0;
         DIG2 <= 4'd0;
         DIG3 <= 4'd0;
      end else if (!hd2) begin
         DIG0 <= d0;
         DIG1 <= d1;
         DIG2 <= d2;
         DIG3 <= d3;
      end
   end

   assign RUNNING = running;
   assign WRAP    = wrap;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb/tb_bcd_stopwatch.sv - directed and randomized checks of bcd_stopwatch against an integer reference model
module tb_bcd_stopwatch;

   localparam int TD = 4;

   logic       CLK;
   logic       RESETN;
   logic       START_STOP;
   logic       CLEAR;
   logic       HOLD;
   logic [3:0] DIG3, DIG2, DIG1, DIG0;
   logic       RUNNING;
   logic       WRAP;

   bcd_stopwatch #(.TICK_DIV(TD)) dut (
      .CLK(CLK),
      .RESETN(RESETN),
      .START_STOP(START_STOP),
      .CLEAR(CLEAR),
      .HOLD(HOLD),
      .DIG3(DIG3),
      .DIG2(DIG2),
      .DIG1(DIG1),
      .DIG0(DIG0),
      .RUNNING(RUNNING),
      .WRAP(WRAP)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: time as an integer count of hundredths, inputs as sample history
   bit m_run;
   int m_cnt;
   int m_phase;
   bit m_wrap;
   int m_disp;
   bit h_ss[3];
   bit h_cl[3];
   bit h_hd[2];

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r;
      r[15:12] = 4'((n / 1000) % 10);
      r[11:8]  = 4'((n / 100) % 10);
      r[7:4]   = 4'((n / 10) % 10);
      r[3:0]   = 4'(n % 10);
      return r;
   endfunction

   function automatic logic [15:0] digs();
      return {DIG3, DIG2, DIG1, DIG0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_cnt = 0; m_phase = 0; m_wrap = 0; m_disp = 0;
      for (int i = 0; i < 3; i++) begin
         h_ss[i] = 0;
         h_cl[i] = 0;
      end
      h_hd[0] = 0;
      h_hd[1] = 0;
   endtask

   task automatic model_edge(input bit ss, input bit cl, input bit hd);
      bit p_ss, p_cl, tk;
      p_ss = h_ss[1] && !h_ss[2];
      p_cl = h_cl[1] && !h_cl[2];
      if (!h_hd[1]) m_disp = m_cnt;
      tk = m_run && (m_phase == TD - 1);
      m_wrap = 0;
      if (p_cl) begin
         m_cnt = 0;
         m_phase = 0;
      end else if (tk) begin
         m_wrap = (m_cnt == 9999);
         m_cnt = (m_cnt + 1) % 10000;
         m_phase = 0;
      end else if (m_run) begin
         m_phase++;
      end
      if (p_ss) m_run = !m_run;
      h_ss[2] = h_ss[1]; h_ss[1] = h_ss[0]; h_ss[0] = ss;
      h_cl[2] = h_cl[1]; h_cl[1] = h_cl[0]; h_cl[0] = cl;
      h_hd[1] = h_hd[0]; h_hd[0] = hd;
   endtask

   task automatic step(input bit ss, input bit cl, input bit hd);
      START_STOP = ss;
      CLEAR = cl;
      HOLD = hd;
      @(posedge CLK);
      if (!RESETN) model_reset();
      else model_edge(ss, cl, hd);
      #1;
      check("cycle", {14'd0, digs(), RUNNING, WRAP}, {14'd0, to_bcd(m_disp), m_run, m_wrap});
   endtask

   int pause_val;
   bit hd_r;

   initial begin
      RESETN = 1'b0;
      START_STOP = 1'b0;
      CLEAR = 1'b0;
      HOLD = 1'b0;
      model_reset();

      // reset with toggling inputs
      for (int i = 0; i < 6; i++) step(1'($urandom), 1'($urandom), 1'($urandom));
      check("reset_outs", {digs(), RUNNING, WRAP}, 18'd0);
      START_STOP = 1'b0; CLEAR = 1'b0; HOLD = 1'b0;
      RESETN = 1'b1;
      for (int i = 0; i < 10; i++) step(0, 0, 0);
      check("idle_after_reset", {digs(), RUNNING, WRAP}, 18'd0);

      // start and count
      step(1, 0, 0);
      step(1, 0, 0);
      check("run_before", RUNNING, 1'b0);
      step(1, 0, 0);
      check("run_rise", RUNNING, 1'b1);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      check("dig0_pre", DIG0, 4'd0);
      step(0, 0, 0);
      check("dig0_first", DIG0, 4'd1);
      for (int i = 0; i < 40; i++) step(0, 0, 0);
      check("digits_0011", digs(), 16'h0011);

      // carry and wrap
      for (int i = 0; i < 45000 && m_disp != 9999; i++) step(0, 0, 0);
      check("digits_9999", digs(), 16'h9999);
      for (int i = 0; i < 8 && !WRAP; i++) step(0, 0, 0);
      check("wrap_seen", WRAP, 1'b1);
      check("digits_at_wrap", digs(), 16'h9999);
      step(0, 0, 0);
      check("wrap_one_cycle", WRAP, 1'b0);
      check("digits_after_wrap", digs(), 16'h0000);

      // pause with pre=2, then resume
      for (int i = 0; i < 8 && m_phase != 3; i++) step(0, 0, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      check("pause_stopped", RUNNING, 1'b0);
      step(0, 0, 0);
      pause_val = m_disp;
      for (int i = 0; i < 20; i++) step(0, 0, 0);
      check("pause_frozen", digs(), to_bcd(pause_val));
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      check("resume_run", RUNNING, 1'b1);
      step(0, 0, 0);
      step(0, 0, 0);
      check("resume_not_yet", digs(), to_bcd(pause_val));
      step(0, 0, 0);
      check("resume_incr", digs(), to_bcd(pause_val + 1));

      // clear while running at 12.34
      for (int i = 0; i < 6000 && m_disp != 1234; i++) step(0, 0, 0);
      check("digits_1234", digs(), 16'h1234);
      step(0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      check("clear_run_digits", digs(), 16'h0000);
      check("clear_run_running", RUNNING, 1'b1);

      // simultaneous clear and start/stop
      for (int i = 0; i < 20; i++) step(0, 0, 0);
      step(1, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      check("simul_running", RUNNING, 1'b0);
      check("simul_digits", digs(), 16'h0000);

      // clear landing on a tick edge
      step(1, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 0, 0);
      for (int i = 0; i < 8 && m_phase != 1; i++) step(0, 0, 0);
      step(0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      check("clear_tick_zero", digs(), 16'h0000);
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      check("clear_tick_noinc", {digs(), WRAP}, 17'd0);
      step(0, 0, 0);
      check("clear_tick_next", digs(), 16'h0001);

      // hold at 05.00 for 100 ticks
      step(0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      for (int i = 0; i < 3000 && m_disp != 500; i++) step(0, 0, 0);
      check("digits_0500", digs(), 16'h0500);
      for (int i = 0; i < 1000 && m_cnt != 600; i++) step(0, 0, 1);
      check("hold_frozen", digs(), 16'h0500);
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      check("hold_release", digs(), 16'h0600);

      // randomized traffic, checked every cycle by the model
      hd_r = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(7) == 0) hd_r = !hd_r;
         step($urandom_range(15) == 0, $urandom_range(31) == 0, hd_r);
      end

      // asynchronous reset mid-count
      for (int i = 0; i < 5; i++) step(0, 0, 0);
      if (!m_run) begin
         step(1, 0, 0);
         for (int i = 0; i < 10; i++) step(0, 0, 0);
      end
      RESETN = 1'b0;
      #2;
      check("async_reset", {digs(), RUNNING, WRAP}, 18'd0);
      step(0, 0, 0);
      step(0, 0, 0);
      RESETN = 1'b1;
      for (int i = 0; i < 5; i++) step(0, 0, 0);
      check("post_reset_idle", {digs(), RUNNING, WRAP}, 18'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
